// File: rtl/conv_out_packer_pkg.sv
// Shared types and constants for the conv output packer: FSM states,
// configuration word field positions and pixel saturation bounds.
package conv_out_packer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CFG_SHIFT   = 0;
    localparam int CFG_SHIFT_W = 5;
    localparam int CFG_RELU    = 5;
    localparam int CFG_ROUND   = 6;

    localparam int B_PIXEL_DEF = 16;

    function automatic longint pix_max(input int bp);
        return (longint'(1) << (bp - 1)) - 1;
    endfunction

    function automatic longint pix_min(input int bp);
        return -(longint'(1) << (bp - 1));
    endfunction

endpackage

// File: rtl/conv_out_packer_if.sv
// Configuration, accumulator input and packed-pixel output bundle of conv_out_packer.
interface conv_out_packer_if #(
    parameter int N_KERNEL   = 4,
    parameter int B_PIXEL    = 16,
    parameter int DATA_WIDTH = 64,
    parameter int B_CNT      = 20
);
    localparam int SEL_W = (N_KERNEL > 1) ? $clog2(N_KERNEL) : 1;

    logic                            cfg_we_i;
    logic [31:0]                     cfg_i;
    logic                            bias_we_i;
    logic [SEL_W-1:0]                bias_sel_i;
    logic [2*B_PIXEL-1:0]            bias_i;
    logic                            start_i;
    logic [B_CNT-1:0]                n_out_i;
    logic [2*B_PIXEL*N_KERNEL-1:0]   acc_i;
    logic                            acc_valid_i;
    logic                            pipe_stall_o;
    logic [DATA_WIDTH-1:0]           do_o;
    logic                            do_valid_o;
    logic                            do_ready_i;
    logic                            busy_o;
    logic                            done_o;
    logic                            ovf_err_o;

    modport slave (
        input  cfg_we_i, cfg_i, bias_we_i, bias_sel_i, bias_i, start_i, n_out_i,
        input  acc_i, acc_valid_i, do_ready_i,
        output pipe_stall_o, do_o, do_valid_o, busy_o, done_o, ovf_err_o
    );

    modport master (
        output cfg_we_i, cfg_i, bias_we_i, bias_sel_i, bias_i, start_i, n_out_i,
        output acc_i, acc_valid_i, do_ready_i,
        input  pipe_stall_o, do_o, do_valid_o, busy_o, done_o, ovf_err_o
    );

endinterface

// File: rtl/conv_out_packer_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         pop_eff;
    logic         push_eff;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_eff  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign push_eff = push_i && (!full_o || pop_eff);
    assign count_o  = wr_q - rd_q;
    assign dout_o   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_eff) wr_q <= wr_q + 1'b1;
            if (pop_eff)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/conv_out_packer.sv
// Output stage after the last conv_unit: bias add, requantize, optional ReLU,
// pack N_KERNEL pixels per word and buffer them for DDR write-back.
module conv_out_packer
    import conv_out_packer_pkg::*;
#(
    parameter int N_KERNEL     = 4,
    parameter int B_PIXEL      = B_PIXEL_DEF,
    parameter int DATA_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 64,
    parameter int STALL_MARGIN = 12,
    parameter int B_CNT        = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_out_packer_if.slave      bus
);
    localparam int ACC_W = 2 * B_PIXEL;
    localparam int SUM_W = ACC_W + 1;
    localparam int SHF_W = ACC_W + 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic signed [SHF_W-1:0] SAT_HI = SHF_W'(pix_max(B_PIXEL));
    localparam logic signed [SHF_W-1:0] SAT_LO = SHF_W'(pix_min(B_PIXEL));

    if (DATA_WIDTH != B_PIXEL * N_KERNEL) begin : g_bad_width
        $error("DATA_WIDTH must equal B_PIXEL*N_KERNEL");
    end

    function automatic logic signed [SHF_W-1:0] round_shift(
        input logic signed [SUM_W-1:0] s,
        input logic [CFG_SHIFT_W-1:0]  sh,
        input logic                    rnd_en
    );
        logic signed [SHF_W-1:0] x;
        x = {s[SUM_W-1], s};
        if (rnd_en && sh != '0) x = x + (SHF_W'(1) << (sh - 1'b1));
        return x >>> sh;
    endfunction

    function automatic logic [B_PIXEL-1:0] sat_relu(
        input logic signed [SHF_W-1:0] x,
        input logic                    relu
    );
        logic signed [SHF_W-1:0] y;
        if (x > SAT_HI)      y = SAT_HI;
        else if (x < SAT_LO) y = SAT_LO;
        else                 y = x;
        if (relu && y < 0) y = '0;
        return y[B_PIXEL-1:0];
    endfunction

    state_t                  state_q;
    logic [B_CNT-1:0]        n_out_q;
    logic [B_CNT-1:0]        acc_cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    stall_q;
    logic [CFG_SHIFT_W-1:0]  shift_q;
    logic                    relu_q;
    logic                    round_q;
    logic signed [ACC_W-1:0] bias_q [N_KERNEL];
    logic                    vld_p1, vld_p2, vld_p3;
    logic [DATA_WIDTH-1:0]   pack_p3;

    logic                    accept;
    logic [1:0]              inflight;
    logic                    stall_d;
    logic                    pop;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [AW:0]             fifo_cnt;
    logic [DATA_WIDTH-1:0]   fifo_dout;

    assign accept   = bus.acc_valid_i && (state_q == RUN) && (acc_cnt_q < n_out_q);
    assign inflight = {1'b0, vld_p1} + {1'b0, vld_p2} + {1'b0, vld_p3};
    assign stall_d  = (int'(fifo_cnt) + int'(inflight)) >= (FIFO_DEPTH - STALL_MARGIN);
    assign pop      = !fifo_empty && bus.do_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            relu_q  <= 1'b0;
            round_q <= 1'b0;
            for (int k = 0; k < N_KERNEL; k++) bias_q[k] <= '0;
        end else if (!busy_q) begin
            if (bus.cfg_we_i) begin
                shift_q <= bus.cfg_i[CFG_SHIFT +: CFG_SHIFT_W];
                relu_q  <= bus.cfg_i[CFG_RELU];
                round_q <= bus.cfg_i[CFG_ROUND];
            end
            if (bus.bias_we_i) bias_q[bus.bias_sel_i] <= bus.bias_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            n_out_q   <= '0;
            acc_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            stall_q   <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
        end else begin
            vld_p1  <= accept;
            vld_p2  <= vld_p1;
            vld_p3  <= vld_p2;
            stall_q <= stall_d;
            done_q  <= 1'b0;
            if (vld_p3 && fifo_full && !pop) ovf_q <= 1'b1;
            unique case (state_q)
                IDLE: if (bus.start_i) begin
                    n_out_q   <= bus.n_out_i;
                    acc_cnt_q <= '0;
                    ovf_q     <= 1'b0;
                    busy_q    <= 1'b1;
                    if (bus.n_out_i == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
                    if (acc_cnt_q == n_out_q) state_q <= DRAIN;
                end
                DRAIN: if (inflight == 2'd0 && fifo_empty) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < N_KERNEL; k++) begin : g_lane
        logic signed [ACC_W-1:0]   acc_k;
        logic signed [SUM_W-1:0]   sum_p1;
        logic signed [SHF_W-1:0]   shf_p2;
        logic        [B_PIXEL-1:0] pix_p3;

        assign acc_k = bus.acc_i[k*ACC_W +: ACC_W];

        // S1: widened bias add
        always_ff @(posedge clk) begin
            if (accept) sum_p1 <= {acc_k[ACC_W-1], acc_k} + {bias_q[k][ACC_W-1], bias_q[k]};
        end

        // S2: round and arithmetic shift
        always_ff @(posedge clk) begin
            if (vld_p1) shf_p2 <= round_shift(sum_p1, shift_q, round_q);
        end

        // S3: saturate, ReLU, pack
        always_ff @(posedge clk) begin
            if (vld_p2) pix_p3 <= sat_relu(shf_p2, relu_q);
        end

        assign pack_p3[k*B_PIXEL +: B_PIXEL] = pix_p3;
    end

    sync_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vld_p3),
        .din_i   (pack_p3),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_cnt)
    );

    assign bus.do_o         = fifo_empty ? '0 : fifo_dout;
    assign bus.do_valid_o   = !fifo_empty;
    assign bus.pipe_stall_o = stall_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer: requant vector table plus multi-cycle
// sequences for backpressure, overflow, beat dropping and mid-job reset.
module tb_conv_out_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_out_packer_if bus ();

    conv_out_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [4:0]  shift;
        logic        relu;
        logic        rnd;
        logic [31:0] bias;
        logic [31:0] acc;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic add_vec(input string n, input int sh, input bit relu, input bit rnd,
                           input int bias, input int acc, input logic [15:0] exp);
        vec_t v;
        v.name  = n;
        v.shift = 5'(sh);
        v.relu  = relu;
        v.rnd   = rnd;
        v.bias  = 32'(bias);
        v.acc   = 32'(acc);
        v.exp   = exp;
        vq.push_back(v);
    endtask

    function automatic logic [127:0] mk_acc(input int idx);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'(idx * 4 + k);
        return r;
    endfunction

    function automatic logic [63:0] mk_exp(input int idx);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = 16'(idx * 4 + k);
        return r;
    endfunction

    task automatic write_cfg(input logic [4:0] sh, input logic relu, input logic rnd);
        bus.cfg_we_i = 1'b1;
        bus.cfg_i    = {25'd0, rnd, relu, sh};
        tick();
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic write_bias(input int sel, input logic [31:0] b);
        bus.bias_we_i  = 1'b1;
        bus.bias_sel_i = 2'(sel);
        bus.bias_i     = b;
        tick();
        bus.bias_we_i  = 1'b0;
    endtask

    task automatic start_job(input int n);
        bus.start_i = 1'b1;
        bus.n_out_i = 20'(n);
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [127:0] acc, input logic [63:0] exp);
        int t;
        start_job(1);
        bus.acc_i       = acc;
        bus.acc_valid_i = 1'b1;
        tick();
        bus.acc_valid_i = 1'b0;
        t = 0;
        while (!bus.do_valid_o && t < 20) begin
            tick();
            t++;
        end
        check({name, "_valid"}, 64'(bus.do_valid_o), 64'd1);
        check({name, "_do"}, bus.do_o, exp);
        bus.do_ready_i = 1'b1;
        tick();
        bus.do_ready_i = 1'b0;
        check({name, "_popped"}, 64'(bus.do_valid_o), 64'd0);
        check({name, "_done_early"}, 64'(bus.done_o), 64'd0);
        tick();
        check({name, "_done"}, 64'(bus.done_o), 64'd1);
        tick();
        check({name, "_done_clr"}, 64'(bus.done_o), 64'd0);
        check({name, "_idle"}, 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent, rcv, bad, dones, sent_at_stall, cyc;
        bit stall_seen, ovf_seen;

        bus.cfg_we_i = 0; bus.cfg_i = '0; bus.bias_we_i = 0; bus.bias_sel_i = '0;
        bus.bias_i = '0; bus.start_i = 0; bus.n_out_i = '0; bus.acc_i = '0;
        bus.acc_valid_i = 0; bus.do_ready_i = 0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_valid", 64'(bus.do_valid_o), 64'd0);
        check("rst_do", bus.do_o, 64'd0);
        check("rst_stall", 64'(bus.pipe_stall_o), 64'd0);
        check("rst_ovf", 64'(bus.ovf_err_o), 64'd0);
        rst = 1'b0;
        tick();

        // name, shift, relu, round, bias, acc, expected pixel
        add_vec("pass5",     0,  0, 0, 0,            5,            16'h0005);
        add_vec("satpos",    0,  0, 0, 0,            32'h00010000, 16'h7FFF);
        add_vec("satneg",    0,  0, 0, 0,            -100000,      16'h8000);
        add_vec("relu_neg",  0,  1, 0, 0,            -7,           16'h0000);
        add_vec("rnd_p3",    1,  0, 1, 0,            3,            16'h0002);
        add_vec("rnd_m3",    1,  0, 1, 0,            -3,           16'hFFFF);
        add_vec("trunc_p3",  1,  0, 0, 0,            3,            16'h0001);
        add_vec("bias_neg",  0,  0, 0, -10,          4,            16'hFFFA);
        add_vec("relu_pos",  0,  1, 0, 0,            100,          16'h0064);
        add_vec("rnd_sh4",   4,  0, 1, 0,            1000,         16'h003F);
        add_vec("trunc_m1k", 4,  0, 0, 0,            -1000,        16'hFFC1);
        add_vec("sum33_pos", 0,  0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 16'h7FFF);
        add_vec("sum33_neg", 0,  0, 0, 32'h80000000, 32'h80000000, 16'h8000);
        add_vec("rnd_sh31",  31, 0, 1, 0,            32'h40000000, 16'h0001);

        foreach (vq[i]) begin
            write_cfg(vq[i].shift, vq[i].relu, vq[i].rnd);
            for (int k = 0; k < 4; k++) write_bias(k, vq[i].bias);
            run_one(vq[i].name, {4{vq[i].acc}}, {4{vq[i].exp}});
        end

        // Per-lane bias and lane ordering
        write_cfg(5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) write_bias(k, 32'(k + 1));
        run_one("lanes", {32'd40, 32'd30, 32'd20, 32'd10}, {16'd44, 16'd33, 16'd22, 16'd11});
        for (int k = 0; k < 4; k++) write_bias(k, 32'd0);

        // Backpressure obeyed: stall must rise before the FIFO can overflow
        start_job(100);
        sent = 0; rcv = 0; bad = 0; dones = 0; sent_at_stall = -1;
        stall_seen = 0; ovf_seen = 0; cyc = 0;
        while (cyc < 3000 && dones == 0) begin
            if (bus.done_o) dones++;
            if (bus.ovf_err_o) ovf_seen = 1;
            if (bus.pipe_stall_o && !stall_seen) begin
                stall_seen    = 1;
                sent_at_stall = sent;
            end
            bus.do_ready_i = stall_seen;
            if (bus.do_valid_o && stall_seen) begin
                if (bus.do_o !== mk_exp(rcv)) bad++;
                rcv++;
            end
            if (!bus.pipe_stall_o && sent < 100) begin
                bus.acc_i       = mk_acc(sent);
                bus.acc_valid_i = 1'b1;
                sent++;
            end else begin
                bus.acc_valid_i = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.acc_valid_i = 1'b0;
        bus.do_ready_i  = 1'b0;
        check("bp_sent_at_stall", 64'(sent_at_stall), 64'd53);
        check("bp_words", 64'(rcv), 64'd100);
        check("bp_order_errs", 64'(bad), 64'd0);
        check("bp_ovf", 64'(ovf_seen), 64'd0);
        check("bp_done", 64'(dones), 64'd1);

        // Stall ignored: FIFO fills, later words dropped, ovf sticky
        start_job(70);
        for (int i = 0; i < 70; i++) begin
            bus.acc_i       = mk_acc(i);
            bus.acc_valid_i = 1'b1;
            tick();
        end
        bus.acc_valid_i = 1'b0;
        repeat (8) tick();
        check("ovf_flag", 64'(bus.ovf_err_o), 64'd1);
        check("ovf_valid", 64'(bus.do_valid_o), 64'd1);
        check("ovf_busy", 64'(bus.busy_o), 64'd1);
        check("ovf_stall", 64'(bus.pipe_stall_o), 64'd1);
        bus.do_ready_i = 1'b1;
        rcv = 0; bad = 0; cyc = 0;
        while (bus.do_valid_o && cyc < 200) begin
            if (bus.do_o !== mk_exp(rcv)) bad++;
            rcv++;
            tick();
            cyc++;
        end
        bus.do_ready_i = 1'b0;
        check("ovf_words", 64'(rcv), 64'd64);
        check("ovf_order_errs", 64'(bad), 64'd0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_o) dones++;
            tick();
        end
        check("ovf_done", 64'(dones), 64'd1);
        check("ovf_sticky", 64'(bus.ovf_err_o), 64'd1);

        // n_out=3 with 5 beats; start and cfg writes during RUN are ignored
        write_cfg(5'd0, 1'b0, 1'b0);
        bus.do_ready_i = 1'b1;
        start_job(3);
        check("drop_ovf_cleared", 64'(bus.ovf_err_o), 64'd0);
        rcv = 0; bad = 0; dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done_o) dones++;
            if (bus.do_valid_o) begin
                if (bus.do_o !== mk_exp(rcv)) bad++;
                rcv++;
            end
            bus.acc_valid_i = (c < 5);
            bus.acc_i       = mk_acc(c);
            bus.start_i     = (c == 2);
            bus.n_out_i     = 20'd10;
            bus.cfg_we_i    = (c == 2);
            bus.cfg_i       = {25'd0, 1'b1, 1'b0, 5'd1};
            tick();
        end
        bus.acc_valid_i = 1'b0; bus.start_i = 1'b0; bus.cfg_we_i = 1'b0;
        bus.do_ready_i  = 1'b0;
        check("drop_words", 64'(rcv), 64'd3);
        check("drop_order_errs", 64'(bad), 64'd0);
        check("drop_done", 64'(dones), 64'd1);
        check("drop_idle", 64'(bus.busy_o), 64'd0);

        // Asynchronous reset mid-RUN with words queued
        start_job(20);
        for (int i = 0; i < 10; i++) begin
            bus.acc_i       = mk_acc(i);
            bus.acc_valid_i = 1'b1;
            tick();
        end
        bus.acc_valid_i = 1'b0;
        repeat (6) tick();
        check("mrst_pre_valid", 64'(bus.do_valid_o), 64'd1);
        check("mrst_pre_busy", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        check("mrst_valid", 64'(bus.do_valid_o), 64'd0);
        check("mrst_busy", 64'(bus.busy_o), 64'd0);
        check("mrst_done", 64'(bus.done_o), 64'd0);
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_o) dones++;
            tick();
        end
        check("mrst_no_done", 64'(dones), 64'd0);
        check("mrst_idle_busy", 64'(bus.busy_o), 64'd0);
        check("mrst_idle_valid", 64'(bus.do_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
